// File: rtl/if_fetch.sv
// if_fetch: single-outstanding instruction fetch unit (IDLE/REQ/WAIT/VALID) with redirect flush.
// Define IF_FETCH_CNT_EN to build the accepted-instruction counter behind fetch_cnt.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst_n,
  input  logic [31:0] npc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        irom_req,
  output logic [31:0] irom_addr,
  input  logic        irom_gnt,
  input  logic        irom_rvalid,
  input  logic [31:0] irom_rdata,
  output logic [31:0] pc_o,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic [31:0] fetch_cnt
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_VALID = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_nxt;
  logic            drop_q;
  logic            drop_nxt;
  logic            capture_c;
  logic            req_nxt;
  logic            valid_nxt;
  logic            unused_c;

  // Instructions are word aligned; the low address bits of npc/redirect_pc carry no information.
  assign unused_c = ^{npc[1:0], redirect_pc[1:0]};

  assign pc_o      = pc_q;
  assign irom_addr = pc_q;

  // State, PC, drop flag and registered outputs.
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst_n) begin
      state      <= S_IDLE;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      irom_req   <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
    end else begin
      state      <= state_nxt;
      pc_q       <= pc_nxt;
      drop_q     <= drop_nxt;
      irom_req   <= req_nxt;
      inst_valid <= valid_nxt;
      if (capture_c) begin
        inst    <= irom_rdata;
        inst_pc <= pc_q;
      end
    end
  end

  // Next state, next PC and drop-flag bookkeeping; redirect overrides every PC update.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    drop_nxt  = drop_q;
    capture_c = 1'b0;

    case (state)
      S_IDLE: begin
        state_nxt = S_REQ;
      end
      S_REQ: begin
        if (irom_gnt) begin
          state_nxt = S_WAIT;
          // A grant alongside a redirect still returns data, which belongs to the old path.
          if (redirect_valid) begin
            drop_nxt = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (irom_rvalid) begin
          drop_nxt = 1'b0;
          if (drop_q || redirect_valid) begin
            state_nxt = S_REQ;
          end else begin
            state_nxt = S_VALID;
            capture_c = 1'b1;
          end
        end else if (redirect_valid) begin
          drop_nxt = 1'b1;
        end
      end
      S_VALID: begin
        if (inst_ready || redirect_valid) begin
          state_nxt = S_REQ;
        end
        if (inst_ready) begin
          pc_nxt = {npc[XLEN-1:2], 2'b00};
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    if (redirect_valid) begin
      pc_nxt = {redirect_pc[XLEN-1:2], 2'b00};
    end

    req_nxt   = (state_nxt == S_REQ);
    valid_nxt = (state_nxt == S_VALID);
  end

`ifdef IF_FETCH_CNT_EN
  logic [XLEN-1:0] cnt_q;
  logic            handshake_c;

  assign handshake_c = inst_valid & inst_ready;

  // Accepted-instruction counter, wraps naturally at 2^32.
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst_n) begin
      cnt_q <= '0;
    end else if (handshake_c) begin
      cnt_q <= cnt_q + XLEN'(1);
    end
  end

  assign fetch_cnt = cnt_q;
`else
  assign fetch_cnt = '0;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed bench for if_fetch with a latency-configurable instruction memory,
// a PC/transaction model checked every cycle, and literal expectations per scenario.
module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        cpu_clk;
  logic        cpu_rst_n;
  logic [31:0] npc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        irom_req;
  logic [31:0] irom_addr;
  logic        irom_gnt;
  logic        irom_rvalid;
  logic [31:0] irom_rdata;
  logic [31:0] pc_o;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic [31:0] fetch_cnt;

  logic [31:0] npc_add;
  int          lat;

  int checks = 0;
  int errors = 0;

  if_fetch #(.RESET_PC(RESET_PC)) dut (
    .cpu_clk        (cpu_clk),
    .cpu_rst_n      (cpu_rst_n),
    .npc            (npc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .irom_req       (irom_req),
    .irom_addr      (irom_addr),
    .irom_gnt       (irom_gnt),
    .irom_rvalid    (irom_rvalid),
    .irom_rdata     (irom_rdata),
    .pc_o           (pc_o),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .fetch_cnt      (fetch_cnt)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  assign npc = pc_o + npc_add;

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory: one outstanding request, response after 'lat' cycles.
  logic        pend = 1'b0;
  logic [31:0] pend_addr;
  int          pend_wait;
  always @(posedge cpu_clk) begin
    if (!cpu_rst_n) begin
      pend = 1'b0;
    end else if (irom_req && irom_gnt) begin
      pend      = 1'b1;
      pend_addr = irom_addr;
      pend_wait = lat - 1;
    end
    #1;
    irom_rvalid = 1'b0;
    irom_rdata  = 32'hDEAD_BEEF;
    if (pend) begin
      if (pend_wait == 0) begin
        irom_rvalid = 1'b1;
        irom_rdata  = word(pend_addr);
        pend        = 1'b0;
      end else begin
        pend_wait--;
      end
    end
  end

  // Model: architectural PC, accepted count, and transaction logs.
  logic [31:0] exp_pc;
  logic [31:0] exp_cnt;
  logic        seen_rst = 1'b0;
  logic        prev_rst, prev_hold, prev_stall, prev_redir;
  logic [31:0] prev_addr, prev_inst, prev_ipc;
  int          cyc = 0;
  logic [31:0] gnt_q[$];
  int          gnt_cyc[$];
  logic [31:0] acc_pc[$];
  logic [31:0] acc_inst[$];

  always @(posedge cpu_clk) begin
    cyc++;
    if (!cpu_rst_n) begin
      exp_pc     = RESET_PC;
      exp_cnt    = '0;
      seen_rst   = 1'b1;
      prev_rst   = 1'b1;
      prev_hold  = 1'b0;
      prev_stall = 1'b0;
      prev_redir = 1'b0;
    end else begin
      prev_rst   = 1'b0;
      prev_hold  = irom_req && !irom_gnt && !redirect_valid;
      prev_addr  = irom_addr;
      prev_stall = inst_valid && !inst_ready && !redirect_valid;
      prev_inst  = inst;
      prev_ipc   = inst_pc;
      prev_redir = redirect_valid;
      if (irom_req && irom_gnt) begin
        gnt_q.push_back(irom_addr);
        gnt_cyc.push_back(cyc);
      end
      if (inst_valid && inst_ready) begin
        exp_cnt = exp_cnt + 32'd1;
        acc_pc.push_back(inst_pc);
        acc_inst.push_back(inst);
      end
      if (redirect_valid) exp_pc = redirect_pc & 32'hFFFF_FFFC;
      else if (inst_valid && inst_ready) exp_pc = npc & 32'hFFFF_FFFC;
    end
  end

  // Per-cycle comparison against the model and protocol rules.
  always @(negedge cpu_clk) begin
    if (seen_rst) begin
      chk("pc", pc_o, exp_pc);
      if (prev_rst) begin
        chk("rst_req", 32'(irom_req), 32'd0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
      end
      if (irom_req) chk("req_addr", irom_addr, pc_o);
      chk("req_and_valid", 32'(irom_req & inst_valid), 32'd0);
      if (inst_valid) begin
        chk("inst_pc_eq_pc", inst_pc, pc_o);
        chk("inst_data", inst, word(inst_pc));
      end
      if (prev_hold) begin
        chk("req_hold", 32'(irom_req), 32'd1);
        chk("addr_hold", irom_addr, prev_addr);
      end
      if (prev_stall) begin
        chk("stall_valid", 32'(inst_valid), 32'd1);
        chk("stall_inst", inst, prev_inst);
        chk("stall_inst_pc", inst_pc, prev_ipc);
      end
      if (prev_redir) chk("flush_valid", 32'(inst_valid), 32'd0);
`ifdef IF_FETCH_CNT_EN
      chk("fetch_cnt", fetch_cnt, exp_cnt);
`else
      chk("fetch_cnt_tied", fetch_cnt, 32'd0);
`endif
    end
  end

  task automatic tick();
    @(posedge cpu_clk);
    #2;
  endtask

  task automatic clr();
    gnt_q.delete();
    gnt_cyc.delete();
    acc_pc.delete();
    acc_inst.delete();
  endtask

  task automatic wait_grant(input string name);
    int n = 0;
    while (!(irom_req && irom_gnt) && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (!(irom_req && irom_gnt)) begin
      errors++;
      $display("FAIL %s: no granted request within 50 cycles", name);
    end
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!irom_req && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (!irom_req) begin
      errors++;
      $display("FAIL %s: no request within 50 cycles", name);
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!inst_valid && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (!inst_valid) begin
      errors++;
      $display("FAIL %s: no inst_valid within 50 cycles", name);
    end
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cpu_rst_n      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0500;
    irom_gnt       = 1'b1;
    inst_ready     = 1'b1;
    npc_add        = 32'd4;
    lat            = 1;
    irom_rvalid    = 1'b0;
    irom_rdata     = 32'hDEAD_BEEF;

    // Reset with redirect asserted; reset wins.
    repeat (3) tick();
    cpu_rst_n      = 1'b1;
    redirect_valid = 1'b0;
    clr();
    chk("reset_pc", pc_o, 32'h0000_0000);
    chk("idle_req", 32'(irom_req), 32'd0);
    chk("reset_cnt", fetch_cnt, 32'd0);
    tick();
    chk("first_req", 32'(irom_req), 32'd1);
    chk("first_addr", irom_addr, 32'h0000_0000);

    // Streaming at best-case throughput.
    repeat (12) tick();
    chk("stream_ngnt", 32'(gnt_q.size() >= 3), 32'd1);
    chk("stream_a0", gnt_q[0], 32'h0000_0000);
    chk("stream_a1", gnt_q[1], 32'h0000_0004);
    chk("stream_a2", gnt_q[2], 32'h0000_0008);
    chk("stream_gap01", 32'(gnt_cyc[1] - gnt_cyc[0]), 32'd3);
    chk("stream_gap12", 32'(gnt_cyc[2] - gnt_cyc[1]), 32'd3);
    chk("stream_pc0", acc_pc[0], 32'h0000_0000);
    chk("stream_pc1", acc_pc[1], 32'h0000_0004);
    chk("stream_pc2", acc_pc[2], 32'h0000_0008);
    chk("stream_inst2", acc_inst[2], 32'hC0DE_0008);

    // Decode stall for 5 cycles, then release with misaligned npc.
    inst_ready = 1'b0;
    redirect(32'h0000_1000);
    clr();
    wait_valid("stall_fill");
    chk("stall_pc", inst_pc, 32'h0000_1000);
    repeat (5) tick();
    chk("stall_still_valid", 32'(inst_valid), 32'd1);
    chk("stall_pc_after", inst_pc, 32'h0000_1000);
    chk("stall_inst_after", inst, 32'hC0DE_1000);
    chk("stall_ngnt", 32'(gnt_q.size()), 32'd1);
    npc_add    = 32'h0000_0023;
    inst_ready = 1'b1;
    tick();
    npc_add = 32'd4;
    wait_grant("stall_release");
    chk("stall_next_addr", irom_addr, 32'h0000_1020);

    // Grant withheld for 4 cycles.
    irom_gnt = 1'b0;
    redirect(32'h0000_2000);
    wait_req("gnt_low");
    for (int i = 0; i < 4; i++) begin
      chk("gnt_low_req", 32'(irom_req), 32'd1);
      chk("gnt_low_addr", irom_addr, 32'h0000_2000);
      tick();
    end
    irom_gnt = 1'b1;
    wait_valid("gnt_low_fill");
    chk("gnt_low_inst_pc", inst_pc, 32'h0000_2000);
    chk("gnt_low_inst", inst, 32'hC0DE_2000);

    // Redirect in WAIT, response arrives two cycles later and is dropped.
    lat = 3;
    wait_grant("wait_redir_g");
    tick();
    clr();
    redirect(32'h0000_0103);
    chk("wait_redir_noreq", 32'(irom_req), 32'd0);
    wait_valid("wait_redir_fill");
    chk("wait_redir_addr", gnt_q[0], 32'h0000_0100);
    chk("wait_redir_ngnt", 32'(gnt_q.size()), 32'd1);
    chk("wait_redir_pc", inst_pc, 32'h0000_0100);
    chk("wait_redir_inst", inst, 32'hC0DE_0100);

    // Two redirects while one response is outstanding; only that one is dropped.
    wait_grant("dbl_redir_g");
    tick();
    clr();
    redirect(32'h0000_0200);
    redirect(32'h0000_0300);
    wait_valid("dbl_redir_fill");
    chk("dbl_redir_addr", gnt_q[0], 32'h0000_0300);
    chk("dbl_redir_pc", inst_pc, 32'h0000_0300);

    // Redirect coincident with read data.
    lat = 1;
    wait_grant("rv_redir_g");
    tick();
    clr();
    redirect(32'h0000_0400);
    chk("rv_redir_novalid", 32'(inst_valid), 32'd0);
    chk("rv_redir_req", 32'(irom_req), 32'd1);
    chk("rv_redir_addr", irom_addr, 32'h0000_0400);
    wait_valid("rv_redir_fill");
    chk("rv_redir_pc", inst_pc, 32'h0000_0400);

    // Redirect coincident with grant.
    wait_grant("gnt_redir_g");
    redirect(32'h0000_0500);
    clr();
    chk("gnt_redir_wait", 32'(irom_req), 32'd0);
    wait_valid("gnt_redir_fill");
    chk("gnt_redir_addr", gnt_q[0], 32'h0000_0500);
    chk("gnt_redir_pc", inst_pc, 32'h0000_0500);

    // Redirect and handshake together in VALID.
    redirect(32'h0000_0600);
    chk("valid_redir_req", 32'(irom_req), 32'd1);
    chk("valid_redir_addr", irom_addr, 32'h0000_0600);

    // Reset in WAIT with redirect asserted.
    lat = 3;
    wait_grant("rst_mid_g");
    tick();
    cpu_rst_n      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0700;
    tick();
    tick();
    cpu_rst_n      = 1'b0;
    cpu_rst_n      = 1'b1;
    redirect_valid = 1'b0;
    clr();
    chk("rst_mid_pc", pc_o, RESET_PC);
    chk("rst_mid_valid", 32'(inst_valid), 32'd0);
    wait_valid("rst_mid_fill");
    chk("rst_mid_addr", gnt_q[0], RESET_PC);
    chk("rst_mid_inst", inst, 32'hC0DE_0000);

`ifdef IF_FETCH_CNT_EN
    // Counter wrap from a preloaded value.
    inst_ready = 1'b0;
    lat        = 1;
    tick();
    wait_valid("cnt_fill");
    force dut.cnt_q = 32'hFFFF_FFFE;
    exp_cnt = 32'hFFFF_FFFE;
    tick();
    release dut.cnt_q;
    inst_ready = 1'b1;
    tick();
    wait_valid("cnt_second");
    tick();
    chk("cnt_wrap", fetch_cnt, 32'd0);
`endif

    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
